// File: rtl/avalon_crc_engine.sv
// avalon_crc_engine: Avalon-MM slave CRC accelerator with a write-side data
// FIFO, byte-enable-aware lanes, START/FINISH commands and a done interrupt.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no word held; pops the FIFO as soon as it is non-empty
// S_BYTE | folding lane `lane` of word_q into the CRC, one lane per cycle
module avalon_crc_engine #(
  parameter int          CRC_WIDTH  = 32,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 chipselect,
  input  logic [2:0]           address,
  input  logic                 read,
  output logic [31:0]          readdata,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic [3:0]           byteenable,
  output logic                 waitrequest,
  output logic                 irq,
  output logic [CRC_WIDTH-1:0] crc_export
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CRC_WIDTH-1:0] POLY_W = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] INIT_W = INIT[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] XOR_W  = XOR_OUT[CRC_WIDTH-1:0];

  typedef enum logic {S_IDLE, S_BYTE} state_t;

  logic [35:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          level;
  logic                 fifo_empty, fifo_full, push, pop, busy;
  state_t               state;
  logic [1:0]           lane;
  logic [35:0]          word_q;
  logic [CRC_WIDTH-1:0] crc, result;
  logic [2:0]           ctrl;
  logic                 done, pending;
  logic                 wr_ok, ctrl_wr, status_wr, cmd_wr, start_cmd, finish_cmd;

  // One MSB-first byte step; input reflection follows the live CONTROL bit.
  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c_in,
                                                    input logic [7:0] b_in,
                                                    input logic refl);
    logic [CRC_WIDTH-1:0] c;
    logic [7:0]           b;
    b = b_in;
    if (refl)
      for (int i = 0; i < 8; i++) b[i] = b_in[7-i];
    c = c_in ^ (CRC_WIDTH'(b) << (CRC_WIDTH - 8));
    for (int k = 0; k < 8; k++)
      c = c[CRC_WIDTH-1] ? ((c << 1) ^ POLY_W) : (c << 1);
    return c;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] bitrev(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  // Full stall looks only at the registered level, so a same-cycle pop never releases it.
  assign fifo_empty  = (level == '0);
  assign fifo_full   = (level == (AW+1)'(FIFO_DEPTH));
  assign busy        = (state != S_IDLE) || !fifo_empty;
  assign waitrequest = chipselect && write &&
                       (((address == 3'd0) && fifo_full) ||
                        ((address == 3'd4) && writedata[0] && busy));
  assign wr_ok       = chipselect && write && !waitrequest;
  assign push        = wr_ok && (address == 3'd0);
  assign ctrl_wr     = wr_ok && (address == 3'd2);
  assign status_wr   = wr_ok && (address == 3'd3);
  assign cmd_wr      = wr_ok && (address == 3'd4);
  assign start_cmd   = cmd_wr && writedata[0];
  assign finish_cmd  = cmd_wr && writedata[1];
  // lane stays 0 in S_IDLE, so lane==3 only matches on the last lane of a word
  assign pop         = !fifo_empty && ((state == S_IDLE) || (lane == 2'd3));

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {byteenable, writedata};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Engine FSM: one lane per cycle, next word popped on lane 3 for gapless streaming
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      lane   <= 2'd0;
      word_q <= '0;
      crc    <= INIT_W;
    end else begin
      if (start_cmd)
        crc <= INIT_W;
      else if ((state == S_BYTE) && word_q[32 + lane])
        crc <= crc_byte(crc, word_q[8*lane +: 8], ctrl[0]);
      if (pop) begin
        word_q <= fifo_mem[rd_ptr];
        state  <= S_BYTE;
        lane   <= 2'd0;
      end else if (state == S_BYTE) begin
        if (lane == 2'd3) state <= S_IDLE;
        lane <= lane + 2'd1;
      end
    end
  end

  // CONTROL register and done/pending handshake; a done-set outranks a W1C
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl    <= 3'd0;
      done    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= writedata[2:0];
      if (start_cmd) begin
        done    <= 1'b0;
        pending <= finish_cmd;
      end else begin
        if (status_wr && writedata[3]) done <= 1'b0;
        if (pending && !busy) begin
          done    <= 1'b1;
          pending <= 1'b0;
        end
        if (finish_cmd) pending <= 1'b1;
      end
    end
  end

  assign result     = (ctrl[1] ? bitrev(crc) : crc) ^ XOR_W;
  assign irq        = done && ctrl[2];
  assign crc_export = crc;

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        3'd0:    readdata[CRC_WIDTH-1:0] = crc;
        3'd1:    readdata[CRC_WIDTH-1:0] = result;
        3'd2:    readdata[2:0] = ctrl;
        3'd3:    readdata = {16'd0, 8'(level), 4'd0, done, fifo_full, fifo_empty, busy};
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_crc_engine.sv
// Bench for avalon_crc_engine: two instances share one bus (XOR_OUT default and 0),
// random streams are checked against a bit-serial CRC model, and waitrequest is
// checked every write cycle against a FIFO-occupancy/lane-timing model.
module tb_avalon_crc_engine;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cs, read, write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata, readdata_m, crc_export, crc_export_m;
  logic        waitrequest, waitrequest_m, irq, irq_m;

  int checks = 0, failures = 0;
  int m_lvl = 0, m_eng = 0, stalls = 0;
  bit m_exp_wr, m_push;

  typedef logic [7:0] bq_t[$];
  bq_t stream;

  avalon_crc_engine #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .chipselect(cs), .address(address), .read(read),
    .readdata(readdata), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .irq(irq), .crc_export(crc_export));

  avalon_crc_engine #(.FIFO_DEPTH(4), .XOR_OUT(32'h0)) dut_m (
    .clock(clock), .reset(reset), .chipselect(cs), .address(address), .read(read),
    .readdata(readdata_m), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest_m), .irq(irq_m), .crc_export(crc_export_m));

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-32 over the enabled bytes, in stream order.
  function automatic logic [31:0] model_crc(input bq_t q, input bit rin, input bit rout,
                                            input logic [31:0] xo);
    logic [31:0] c, r;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      b = q[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[31] ^ (rin ? b[k] : b[7-k]);
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    r = c;
    if (rout) for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r ^ xo;
  endfunction

  // Mid-cycle monitor: the FIFO holds words until the engine takes one when idle
  // or on its fourth lane; each word then occupies the engine for four cycles.
  always @(negedge clock) begin
    if (reset) begin
      m_lvl = 0;
      m_eng = 0;
    end else begin
      m_exp_wr = 1'b0;
      if (cs && write) begin
        if (address == 3'd0)                    m_exp_wr = (m_lvl == 4);
        else if (address == 3'd4 && writedata[0]) m_exp_wr = (m_lvl != 0) || (m_eng != 0);
        check_val("waitrequest", 32'(waitrequest), 32'(m_exp_wr));
        check_val("waitrequest_m", 32'(waitrequest_m), 32'(m_exp_wr));
        if (address == 3'd0 && m_exp_wr) stalls++;
      end
      m_push = cs && write && (address == 3'd0) && !m_exp_wr;
      if ((m_eng == 0 || m_eng == 1) && m_lvl > 0) begin
        m_lvl--;
        m_eng = 4;
      end else if (m_eng > 0) begin
        m_eng--;
      end
      if (m_push) m_lvl++;
    end
  end

  task automatic bus_idle();
    cs = 0; read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
  endtask

  // Leaves the bus driven so consecutive calls form a back-to-back burst.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    cs = 1; read = 0; write = 1; address = a; writedata = d; byteenable = be;
    n = 0;
    @(negedge clock);
    while (waitrequest && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (waitrequest) check_val("wr_timeout", 32'(n), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [31:0] d);
    bus_wr(a, d, 4'hF);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d, output logic [31:0] dm);
    cs = 1; read = 1; write = 0; address = a;
    @(negedge clock);
    d  = readdata;
    dm = readdata_m;
    @(posedge clock); #1;
    bus_idle();
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] be);
    bus_wr(3'd0, d, be);
    for (int i = 0; i < 4; i++) if (be[i]) stream.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_done();
    logic [31:0] s, sm;
    int n;
    n = 0;
    do begin
      bus_rd(3'd3, s, sm);
      n++;
    end while (!s[3] && n < 100);
    check_val("done", 32'(s[3]), 32'd1);
  endtask

  task automatic ref_stream();
    stream.delete();
    push_word(32'h34333231, 4'hF);
    push_word(32'h38373635, 4'hF);
    push_word(32'h00000039, 4'h1);
    bus_idle();
  endtask

  initial begin
    #300000;
    check_val("global_timeout", 32'd1, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, dm;
    logic [2:0]  ctl;
    bus_idle();
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // reset state
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_wait", 32'(waitrequest), 32'd0);
    check_val("rst_export", crc_export, 32'hFFFFFFFF);
    check_val("rst_readdata", readdata, 32'd0);
    bus_rd(3'd3, d, dm); check_val("rst_status", d, 32'h2);
    bus_rd(3'd1, d, dm); check_val("rst_result", d, 32'h0);
    check_val("rst_result_m", dm, 32'hFFFFFFFF);
    bus_rd(3'd0, d, dm); check_val("rst_raw", d, 32'hFFFFFFFF);
    bus_rd(3'd2, d, dm); check_val("rst_ctrl", d, 32'h0);
    bus_rd(3'd5, d, dm); check_val("unmapped_rd", d, 32'h0);
    bus_rd(3'd4, d, dm); check_val("cmd_rd", d, 32'h0);

    // CRC-32 (reflected) check value
    wr1(3'd2, 32'h3);
    wr1(3'd4, 32'h1);
    ref_stream();
    wr1(3'd4, 32'h2);
    wait_done();
    bus_rd(3'd1, d, dm);
    check_val("crc32", d, 32'hCBF43926);
    check_val("crc32_m", dm, model_crc(stream, 1'b1, 1'b1, 32'h0));

    // CRC-32/MPEG-2 (no reflection, no xor-out on dut_m)
    wr1(3'd2, 32'h0);
    wr1(3'd4, 32'h1);
    ref_stream();
    wr1(3'd4, 32'h2);
    wait_done();
    bus_rd(3'd1, d, dm);
    check_val("mpeg2_m", dm, 32'h0376E6E7);
    check_val("mpeg2", d, 32'hFC891918);

    // random back-to-back bursts of 12 words with random lanes and reflection
    for (int r = 0; r < 3; r++) begin
      ctl = 3'($urandom_range(0, 3));
      wr1(3'd2, 32'(ctl));
      wr1(3'd4, 32'h1);
      stream.delete();
      stalls = 0;
      for (int w = 0; w < 12; w++) push_word($urandom, 4'($urandom));
      bus_idle();
      wr1(3'd4, 32'h2);
      wait_done();
      bus_rd(3'd1, d, dm);
      check_val("burst_result", d, model_crc(stream, ctl[0], ctl[1], 32'hFFFFFFFF));
      check_val("burst_result_m", dm, model_crc(stream, ctl[0], ctl[1], 32'h0));
      check_val("burst_stalled", 32'(stalls > 0), 32'd1);
    end

    // START immediately behind a burst waits for the drain, then reloads INIT
    wr1(3'd2, 32'h4);
    wr1(3'd4, 32'h1);
    stream.delete();
    for (int w = 0; w < 8; w++) push_word($urandom, 4'hF);
    bus_wr(3'd4, 32'h1, 4'hF);
    bus_idle();
    bus_rd(3'd0, d, dm); check_val("start_raw", d, 32'hFFFFFFFF);
    bus_rd(3'd3, d, dm); check_val("start_status", d, 32'h2);
    check_val("start_irq", 32'(irq), 32'd0);
    wr1(3'd4, 32'h2);
    wait_done();
    check_val("irq_set", 32'(irq), 32'd1);
    wr1(3'd3, 32'h8);
    check_val("irq_w1c", 32'(irq), 32'd0);

    // reset in the middle of a word
    wr1(3'd2, 32'h3);
    wr1(3'd4, 32'h1);
    stream.delete();
    push_word(32'hA5A55A5A, 4'hF);
    push_word(32'h12345678, 4'hF);
    bus_idle();
    @(posedge clock); #1;
    reset = 1;
    #1 check_val("midrst_export", crc_export, 32'hFFFFFFFF);
    cs = 1; read = 1; address = 3'd3;
    #1 check_val("midrst_status", readdata, 32'h2);
    bus_idle();
    @(posedge clock); #3;
    reset = 0;
    @(posedge clock); #1;
    bus_rd(3'd2, d, dm); check_val("midrst_ctrl", d, 32'h0);
    wr1(3'd2, 32'h3);
    wr1(3'd4, 32'h1);
    ref_stream();
    wr1(3'd4, 32'h2);
    wait_done();
    bus_rd(3'd1, d, dm);
    check_val("post_rst_crc32", d, 32'hCBF43926);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avalon_crc_engine.md
# avalon_crc_engine

Parametrised Avalon-MM slave CRC accelerator, successor to the fixed CRC-32 wrapper. Any CRC polynomial and width from 8 to 32 bits, configurable init, xor-out and reflection. Write-side FIFO of configurable depth, byte-enable-aware data lanes, explicit start/finish commands and a done interrupt. Sits on the system interconnect; the raw CRC is also exported to the fabric.

## Interface
- CRC_WIDTH, 32, CRC width in bits (8..32)
- POLY, 32'h04C11DB7, generator polynomial, low CRC_WIDTH bits used
- INIT, 32'hFFFFFFFF, CRC register value after reset/START (low CRC_WIDTH bits)
- XOR_OUT, 32'hFFFFFFFF, value XORed into RESULT (low CRC_WIDTH bits)
- FIFO_DEPTH, 8, data FIFO entries, power of two, >= 2
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- chipselect  in  1  slave select
- address  in  3  word register index
- read  in  1  read strobe
- readdata  out  32  combinational read data, zero-extended
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  lane enables for DATA writes
- waitrequest  out  1  stalls the current write
- irq  out  1  done & IRQ_EN
- crc_export  out  CRC_WIDTH  raw CRC register

## Operation
- Register map:
  - 0 DATA: write pushes {byteenable, writedata} into the FIFO; read returns the raw CRC.
  - 1 RESULT (RO): (REFLECT_OUT ? bitreverse(crc) : crc) ^ XOR_OUT.
  - 2 CONTROL (RW): bit0 REFLECT_IN, bit1 REFLECT_OUT, bit2 IRQ_EN.
  - 3 STATUS: bit0 busy, bit1 fifo_empty, bit2 fifo_full, bit3 done (W1C), bits 15:8 fifo level.
  - 4 CMD (WO): bit0 START reloads the CRC with INIT and clears done; bit1 FINISH arms done.
  - Other addresses: writes ignored, reads return 0. CMD reads return 0.
- Engine FSM states are IDLE and BYTE, with a lane counter 0..3.
  - IDLE: when the FIFO is non-empty, pop into the word register and go to BYTE with lane 0.
  - BYTE: every lane takes one cycle. A lane with its byteenable bit set updates the CRC; a disabled lane leaves it unchanged.
  - At lane 3: if the FIFO is non-empty, pop and restart at lane 0; otherwise go to IDLE.
- Byte update, MSB-first:
  - b = REFLECT_IN ? bitreverse8(byte) : byte.
  - crc ^= b << (CRC_WIDTH-8).
  - Repeat 8 times: crc = msb ? (crc<<1)^POLY : crc<<1, truncated to CRC_WIDTH.
- Lane 0 (writedata[7:0]) is processed first.
- busy = (state != IDLE) | !fifo_empty.
- Done behaviour:
  - FINISH sets pending.
  - When pending and not busy, done sets and pending clears.
  - Writing 1 to STATUS bit3 clears done.
  - START clears both done and pending.
- Changing CONTROL while busy is allowed and takes effect on the next lane processed.

## Timing
- Reset values:
  - crc = INIT, FIFO empty, FSM IDLE, CONTROL = 0, done = 0, pending = 0.
  - irq = 0, waitrequest = 0, crc_export = INIT, readdata = 0.
- Reads are zero-wait-state: readdata is valid in the same cycle as chipselect & read.
- Write stalls:
  - A DATA write stalls (waitrequest = 1) while the FIFO level equals FIFO_DEPTH. The word is accepted in the first cycle that waitrequest = 0.
  - A simultaneous pop does not release a full-FIFO stall in that cycle.
  - A CMD write with START stalls while busy, so START always follows the drained stream.
  - All other writes never stall.
- Data pipeline:
  - A word accepted at edge n is poppable at n+1.
  - Lanes are processed at n+2..n+5; crc_export reflects the last lane after edge n+5.
  - Sustained throughput is 1 byte per cycle with no bubble between words.
- Same-cycle precedence:
  - START and FINISH in one write: START is applied first, and done is set once busy = 0.
  - A done-set and a W1C in the same cycle: the set wins.
- Asserting reset mid-word discards the FIFO contents and the partial word immediately.

## Test plan
- Reset, then read STATUS, RESULT and the DATA readback -> STATUS = 0x00000002; RESULT = 0x00000000; raw = 0xFFFFFFFF; irq = 0.
- CRC-32 reference check with defaults and CONTROL = 3:
  - Stimulus: START; DATA 0x34333231 (be F), 0x38373635 (be F), 0x00000039 (be 1); FINISH.
  - Required: done = 1 and RESULT = 0xCBF43926.
- CRC-32/MPEG-2 check with XOR_OUT = 0 and CONTROL = 0, same stream -> RESULT = 0x0376E6E7.
- FIFO_DEPTH = 4 back-to-back burst of 12 words:
  - waitrequest is asserted exactly while the level is 4.
  - No word is lost or duplicated; RESULT matches a reference model.
- START issued right after a burst:
  - waitrequest holds until busy falls.
  - The CRC then equals INIT.
  - IRQ_EN = 1 with FINISH raises irq; writing 0x8 to STATUS drops irq the next cycle.
- Reset asserted mid-word -> crc_export = INIT asynchronously and fifo_empty = 1. After release, the CRC-32 check stream still yields 0xCBF43926.
